// File: rtl/axis_burst_capture.sv
// AXI-Stream burst capture: accepts one burst of up to DEPTH words into a
// register file and holds it for registered random-access readback.
module axis_burst_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter bit USE_TLAST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    input  logic                  i_s_valid,
    input  logic                  i_s_last,
    output logic                  o_s_ready,
    input  logic                  i_start,
    input  logic [DEPTH_LOG2:0]   i_len,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DEPTH_LOG2:0]   o_count,
    output logic                  o_err_early_last,
    output logic                  o_err_no_last,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LP_DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] LP_ONE       = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0] LP_ZERO      = (DEPTH_LOG2 + 1)'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t                r_state;
    logic [DEPTH_LOG2:0]   r_count;
    logic [DEPTH_LOG2:0]   r_len;
    logic                  r_err_early_last;
    logic                  r_err_no_last;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_buf [DEPTH];

    logic                  w_accept;
    logic                  w_final_beat;
    logic [DEPTH_LOG2:0]   w_len_clamped;

    // Ready is a pure decode of the state register, so it never depends on valid.
    assign w_accept     = i_s_valid && (r_state == ST_RUN);
    assign w_final_beat = (r_count == (r_len - LP_ONE));

    // Zero or oversized lengths mean "fill the whole buffer".
    always_comb begin
        w_len_clamped = i_len;
        if ((i_len == LP_ZERO) || (i_len > LP_DEPTH_CNT)) begin
            w_len_clamped = LP_DEPTH_CNT;
        end else begin
            w_len_clamped = i_len;
        end
    end

    // Burst sequencing: state, beat counter, latched length and sticky errors.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= ST_IDLE;
            r_count          <= LP_ZERO;
            r_len            <= LP_DEPTH_CNT;
            r_err_early_last <= 1'b0;
            r_err_no_last    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_state          <= ST_RUN;
                        r_len            <= w_len_clamped;
                        r_count          <= LP_ZERO;
                        r_err_early_last <= 1'b0;
                        r_err_no_last    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_count <= r_count + LP_ONE;
                        // A completed handshake is kept even when abort wins the state.
                        if (i_abort) begin
                            r_state <= ST_IDLE;
                        end else if (w_final_beat) begin
                            r_state <= ST_DONE;
                            if (USE_TLAST && !i_s_last) begin
                                r_err_no_last <= 1'b1;
                            end
                        end else if (USE_TLAST && i_s_last) begin
                            r_state          <= ST_DONE;
                            r_err_early_last <= 1'b1;
                        end
                    end else if (i_abort) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Capture storage; deliberately never cleared so data survives reset.
    always_ff @(posedge clk) begin
        if (rst && w_accept) begin
            r_buf[r_count[DEPTH_LOG2-1:0]] <= i_s_data;
        end
    end

    // Readback port: one-cycle latency, old data on a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= {DATA_WIDTH{1'b0}};
        end else begin
            r_rd_data <= r_buf[i_rd_addr];
        end
    end

    assign o_s_ready        = (r_state == ST_RUN);
    assign o_busy           = (r_state == ST_RUN);
    assign o_done           = (r_state == ST_DONE);
    assign o_count          = r_count;
    assign o_err_early_last = r_err_early_last;
    assign o_err_no_last    = r_err_no_last;
    assign o_rd_data        = r_rd_data;

endmodule

// File: doc/axis_burst_capture.md
Name: axis_burst_capture

Overview:
AXI-Stream slave that captures one burst of up to DEPTH words into an internal register file, then holds the data for random-access readback.
- Per-burst programmable length, optional TLAST checking, abort, done pulse and sticky error flags.
- Sits behind an AXIS master port and feeds control/processing logic that reads results through rd_addr/rd_data.

Parameters:
DATA_WIDTH, 32, width of s_data and rd_data
DEPTH_LOG2, 4, log2 of capture buffer depth
DEPTH, 2**DEPTH_LOG2, buffer depth in words (derived; not overridden independently)
USE_TLAST, 1, 1 = check s_last against programmed length; 0 = ignore s_last

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low
s_data  input  DATA_WIDTH  AXIS data
s_valid  input  1  AXIS valid
s_last  input  1  AXIS last
s_ready  output  1  AXIS ready
start  input  1  burst start request, sampled in IDLE only
len  input  DEPTH_LOG2+1  burst length in words, latched on accepted start
abort  input  1  terminate burst in progress
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on normal burst completion
count  output  DEPTH_LOG2+1  beats captured in current/last burst
err_early_last  output  1  sticky: s_last seen before programmed length
err_no_last  output  1  sticky: final beat lacked s_last
rd_addr  input  DEPTH_LOG2  readback address
rd_data  output  DATA_WIDTH  registered readback data

Behaviour:
- Reset (rst=0 at clock edge), whatever the state: state=IDLE; s_ready, busy, done, err_early_last, err_no_last = 0; count=0; rd_data=0. Buffer contents are not cleared by reset or by start.
- States:
  - IDLE: start=1 and abort=0 -> RUN. len is latched; len=0 or len>DEPTH clamps to DEPTH. On entry to RUN, count and both err flags are cleared.
  - RUN: s_ready=1; busy=1.
  - DONE: lasts exactly one cycle with done=1, then -> IDLE.
- s_ready and busy decode directly from the registered state: high only in RUN. There is no combinational path from s_valid to s_ready.
- Handshake: beat accepted when s_valid & s_ready. On acceptance, buf[count]<=s_data and count<=count+1.
- Normal completion: accepting beat number len (count==len-1) -> DONE. s_ready drops the next cycle, so no extra beat is ever accepted. If USE_TLAST=1 and s_last=0 on that beat, err_no_last<=1 (done still pulses).
- Early TLAST (USE_TLAST=1): accepted beat with s_last=1 and count<len-1 -> beat stored and counted, err_early_last<=1, -> DONE.
- USE_TLAST=0: s_last is ignored entirely; the burst ends only on count or abort.
- Abort:
  - In RUN: -> IDLE with no done pulse; count and error flags hold.
  - Abort in the same cycle as an accepted beat: the beat is still stored and counted (the handshake has completed), then -> IDLE.
  - Abort in IDLE or DONE: ignored, except that abort=1 together with start=1 in IDLE blocks the start.
- start in RUN or DONE is ignored (not queued).
- count holds its final value in IDLE until the next accepted start. Its width, DEPTH_LOG2+1, lets it reach DEPTH without wrapping.
- Readback: rd_data <= buf[rd_addr] every cycle, giving 1-cycle latency, in any state. A same-cycle write to the same address returns the old word; the new word is visible one cycle later.
- Error flags stay sticky until the next accepted start or reset.

Test Plan:
- DEPTH=16, len=4, USE_TLAST=1; stream 0xA0..0xA3 with s_last on the 4th beat, s_valid toggling 1,0,1,1,0,1 -> done pulses one cycle after 4th accept; count=4; no errors; s_ready low from the cycle after the 4th accept; rd_addr=0..3 returns 0xA0..0xA3 one cycle later.
- len=0 -> 16 beats 0x100..0x10F accepted, done, count=16; 17th s_valid beat sees s_ready=0; rd_addr=15 returns 0x10F.
- len=8, s_last on 3rd beat -> err_early_last=1, count=3, done pulses. Second burst len=2 with correct last -> err_early_last cleared at start; words 0..1 overwritten, word 2 still holds the old value.
- len=4, no s_last on the 4th beat -> err_no_last=1, done=1. Same stimulus with USE_TLAST=0 -> no error.
- len=8, abort asserted in the same cycle as the 3rd accept -> 3 beats stored, count=3, no done, IDLE next cycle. start+abort together in IDLE -> stays IDLE.
- rst=0 mid-burst after 5 beats -> all outputs at reset values next cycle; buffer words 0..4 are still readable after rst=1.
